// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier that borrows an external single-cycle ALU
// to build the low WIDTH bits of op_a*op_b, one add/shift step per cycle.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [3:0]       alu_func,
  input  logic [WIDTH-1:0] alu_ans,
  input  logic             alu_of
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADD  = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [3:0] FUNC_ADD  = 4'b0000;
  localparam logic [3:0] FUNC_SHL  = 4'b1001;
  localparam logic [3:0] FUNC_SHR  = 4'b1000;
  localparam logic [3:0] FUNC_NONE = 4'b1111;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] acc;

  // Overflow is deliberately discarded: the low word wraps by design.
  logic unused_of;
  assign unused_of = alu_of;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
    end else if (flush) begin
      state <= IDLE;
      acc   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start_valid) begin
            mcand <= op_a;
            mplr  <= op_b;
            acc   <= '0;
          end
        end
        ADD:     acc   <= alu_ans;
        SHL:     mcand <= alu_ans;
        SHR:     mplr  <= alu_ans;
        default: ;
      endcase
    end
  end

  // The shifted multiplier coming back from the ALU decides whether to stop,
  // add, or just shift again, so no iteration counter is needed.
  always_comb begin
    state_next = state;
    alu_src1   = '0;
    alu_src2   = '0;
    alu_func   = FUNC_NONE;
    case (state)
      IDLE: begin
        if (start_valid) begin
          if (op_a == '0 || op_b == '0)
            state_next = DONE;
          else if (op_b[0])
            state_next = ADD;
          else
            state_next = SHL;
        end
      end
      ADD: begin
        alu_src1   = acc;
        alu_src2   = mcand;
        alu_func   = FUNC_ADD;
        state_next = SHL;
      end
      SHL: begin
        alu_src1   = mcand;
        alu_src2   = WIDTH'(1);
        alu_func   = FUNC_SHL;
        state_next = SHR;
      end
      SHR: begin
        alu_src1 = mplr;
        alu_src2 = WIDTH'(1);
        alu_func = FUNC_SHR;
        if (alu_ans == '0)
          state_next = DONE;
        else if (alu_ans[0])
          state_next = ADD;
        else
          state_next = SHL;
      end
      DONE: begin
        if (res_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign res         = acc;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed self-checking bench for alu_mul_seq; the bench supplies the ALU.
module tb_alu_mul_seq;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res;
  logic        busy;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  alu_func;
  logic [31:0] alu_ans;
  logic        alu_of;

  int checks = 0;
  int errors = 0;
  logic [3:0] funcs [0:127];
  int n_steps;

  alu_mul_seq #(.WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res(res),
    .busy(busy),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_func(alu_func),
    .alu_ans(alu_ans), .alu_of(alu_of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: add, shift-left, shift-right-logical; any other code yields 0.
  always_comb begin
    case (alu_func)
      4'b0000: alu_ans = alu_src1 + alu_src2;
      4'b1001: alu_ans = alu_src1 << alu_src2[4:0];
      4'b1000: alu_ans = alu_src1 >> alu_src2[4:0];
      default: alu_ans = 32'd0;
    endcase
  end
  assign alu_of = alu_src1[31] ^ alu_src2[0];

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, scramble operands after acceptance, wait for the result.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_steps, input int hold);
    int guard;
    guard = 0;
    while (!start_ready && guard < 10) begin
      tick();
      guard++;
    end
    check_output({tag, "_ready"}, {31'd0, start_ready}, 32'd1);
    op_a = a;
    op_b = b;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    op_a = 32'hDEAD_BEEF;
    op_b = 32'h1357_9BDF;
    n_steps = 0;
    while (!res_valid && n_steps < 200) begin
      if (n_steps < 128) funcs[n_steps] = alu_func;
      tick();
      n_steps++;
    end
    check_output({tag, "_steps"}, n_steps, exp_steps);
    check_output({tag, "_res"}, res, exp_res);
    check_output({tag, "_donefunc"}, {28'd0, alu_func}, 32'hF);
    for (int k = 0; k < hold; k++) begin
      tick();
      check_output({tag, "_holdvalid"}, {31'd0, res_valid}, 32'd1);
      check_output({tag, "_holdres"}, res, exp_res);
      check_output({tag, "_holdready"}, {31'd0, start_ready}, 32'd0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_output({tag, "_idle"}, {30'd0, busy, start_ready}, 32'd1);
  endtask

  initial begin
    logic [3:0] exp_funcs [0:7];
    bit seen;
    int guard;
    exp_funcs = '{4'h0, 4'h9, 4'h8, 4'h9, 4'h8, 4'h0, 4'h9, 4'h8};
    rstn = 1'b0;
    flush = 1'b0;
    start_valid = 1'b0;
    res_ready = 1'b0;
    op_a = 32'd0;
    op_b = 32'd0;
    #12;
    check_output("rst_ready", {31'd0, start_ready}, 32'd1);
    check_output("rst_valid", {31'd0, res_valid}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_res", res, 32'd0);
    check_output("rst_src", alu_src1 | alu_src2, 32'd0);
    check_output("rst_func", {28'd0, alu_func}, 32'hF);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    run_mul("m3x5", 32'd3, 32'd5, 32'd15, 8, 0);
    for (int i = 0; i < 8; i++)
      check_output($sformatf("m3x5_func%0d", i), {28'd0, funcs[i]}, {28'd0, exp_funcs[i]});

    run_mul("bzero", 32'h1234_5678, 32'd0, 32'd0, 0, 0);
    run_mul("azero", 32'd0, 32'd7, 32'd0, 0, 0);
    run_mul("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 96, 0);
    run_mul("neg7x6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 8, 0);
    run_mul("hold9x4", 32'd9, 32'd4, 32'd36, 7, 5);

    // Flush on the 4th busy edge must abort without a result.
    op_a = 32'd5;
    op_b = 32'h80;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (res_valid) seen = 1'b1;
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_output("flush_idle", {30'd0, busy, start_ready}, 32'd1);
    check_output("flush_acc", res, 32'd0);
    for (int k = 0; k < 4; k++) begin
      if (res_valid) seen = 1'b1;
      tick();
    end
    check_output("flush_noresult", {31'd0, seen}, 32'd0);
    run_mul("after_flush", 32'd2, 32'd3, 32'd6, 6, 0);

    // Flush in IDLE blocks acceptance.
    op_a = 32'd3;
    op_b = 32'd5;
    start_valid = 1'b1;
    flush = 1'b1;
    tick();
    start_valid = 1'b0;
    flush = 1'b0;
    check_output("idleflush_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset while in SHL.
    op_a = 32'd3;
    op_b = 32'd5;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    guard = 0;
    while (alu_func != 4'h9 && guard < 20) begin
      tick();
      guard++;
    end
    check_output("rst_mid_inshl", {28'd0, alu_func}, 32'h9);
    #2;
    rstn = 1'b0;
    #1;
    check_output("rstmid_ready", {30'd0, busy, start_ready}, 32'd1);
    check_output("rstmid_func", {28'd0, alu_func}, 32'hF);
    check_output("rstmid_src", alu_src1 | alu_src2, 32'd0);
    check_output("rstmid_res", {res[31:1], res[0] | res_valid}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    run_mul("after_rst", 32'd2, 32'd3, 32'd6, 6, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
